// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master bridging a valid/ready command port to APB transfers.
// Optional ACCESS timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;

    // ready is gated by reset so it drops the instant reset asserts and rises as soon as it releases
    assign cmd_ready = (state == IDLE) && !PRESET;

`ifndef APB_MASTER_TIMEOUT_EN
    assign rsp_error = 1'b0;
`endif

    // transfer sequencer: all APB and response outputs are registered here
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_error <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_error <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state    <= SETUP;
                        PSEL     <= 1'b1;
                        PWRITE   <= cmd_write;
                        PADDR    <= cmd_addr;
                        PWDATA   <= cmd_wdata;
                        wait_cnt <= '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                    end
`endif
                    else if (wait_cnt != CW'(TIMEOUT_CYCLES)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed checks of apb_master against a small APB slave model.
module tb_apb_master;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int total = 0;
    int bad = 0;

    bit [31:0] mem [16];
    int        acc_cnt = 0;
    int        wait_n = 0;
    bit        force_low = 1'b0;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // slave: ready after wait_n ACCESS cycles, 0x1F is a fixed read-only word
    assign PREADY = !force_low && (acc_cnt >= wait_n);
    assign PRDATA = (PADDR == 32'h1F) ? 32'h12345678 : mem[PADDR[3:0]];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[3:0]] <= PWDATA;
        acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int cyc, output int ps, output int pe, output int unstable);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        cyc = 0; ps = 0; pe = 0; unstable = 0;
        rd = 'x; er = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            cmd_valid = 1'b0;
            cyc++;
            if (PSEL) begin
                ps++;
                if (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) unstable++;
            end
            if (PENABLE) pe++;
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_error;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc, ps, pe, unst, n, busy_bad, k, pulses, gaps, gap_bad, low_run;
        bit          started, got_rsp;
        int          acc [4];

        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        #2;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_psel", {PSEL, PENABLE, rsp_valid, rsp_error}, 0);
        chk("rst_bus", {PADDR, PWDATA}, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("rel_ready", cmd_ready, 1);

        xfer(1'b1, 32'h5, 32'hDEADBEEF, rd, er, cyc, ps, pe, unst);
        chk("wr_cycles", cyc, 3);
        chk("wr_psel", ps, 2);
        chk("wr_penable", pe, 1);
        chk("wr_resp", {er, rd}, {1'b0, 32'h0});
        chk("wr_stable", unst, 0);

        xfer(1'b0, 32'h5, 32'h0, rd, er, cyc, ps, pe, unst);
        chk("rd_cycles", cyc, 3);
        chk("rd_resp", {er, rd}, {1'b0, 32'hDEADBEEF});

        wait_n = 3;
        xfer(1'b0, 32'h1F, 32'h0, rd, er, cyc, ps, pe, unst);
        chk("ws_penable", pe, 4);
        chk("ws_cycles", cyc, 6);
        chk("ws_stable", unst, 0);
        chk("ws_resp", {er, rd}, {1'b0, 32'h12345678});

`ifdef APB_MASTER_TIMEOUT_EN
        force_low = 1'b1;
        xfer(1'b0, 32'h7, 32'h0, rd, er, cyc, ps, pe, unst);
        chk("to_penable", pe, 4);
        chk("to_resp", {er, rd}, {1'b1, 32'h0});
        chk("to_ready", cmd_ready, 1);
        force_low = 1'b0;
`else
        wait_n = 10;
        xfer(1'b0, 32'h1F, 32'h0, rd, er, cyc, ps, pe, unst);
        chk("nto_penable", pe, 11);
        chk("nto_resp", {er, rd}, {1'b0, 32'h12345678});
`endif
        wait_n = 0;

        cmd_write = 1'b0; cmd_addr = 32'h5; cmd_valid = 1'b1;
        @(negedge PCLK);
        cmd_write = 1'b1; cmd_addr = 32'h2; cmd_wdata = 32'hA5A5A5A5;
        busy_bad = 0; n = 1;
        while (!rsp_valid && n < 50) begin
            if (cmd_ready) busy_bad++;
            @(negedge PCLK);
            n++;
        end
        chk("busy_ready", busy_bad, 0);
        chk("busy_rd", {rsp_valid, rsp_rdata}, {1'b1, 32'hDEADBEEF});
        chk("busy_idle_ready", cmd_ready, 1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("busy2_setup", {PSEL, PENABLE, PWRITE}, 3'b101);
        chk("busy2_paddr", PADDR, 32'h2);
        got_rsp = 1'b0;
        for (int i = 0; i < 10 && !got_rsp; i++) begin
            @(negedge PCLK);
            got_rsp = rsp_valid;
        end
        chk("busy2_rsp", got_rsp, 1);
        chk("busy2_mem", mem[2], 32'hA5A5A5A5);

        wait_n = 5;
        cmd_write = 1'b0; cmd_addr = 32'h1F; cmd_valid = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1;
        chk("mr_apb", {PSEL, PENABLE, PWRITE}, 0);
        chk("mr_bus", {PADDR, PWDATA}, 0);
        chk("mr_rsp", {cmd_ready, rsp_valid, rsp_error, rsp_rdata}, 0);
        @(negedge PCLK);
        chk("mr_norsp", rsp_valid, 0);
        PRESET = 1'b0;
        wait_n = 0;
        #1;
        chk("mr_ready", cmd_ready, 1);
        xfer(1'b1, 32'h0, 32'h11, rd, er, cyc, ps, pe, unst);
        chk("mr_after", {cyc[7:0], er}, {8'd3, 1'b0});
        chk("mr_after_mem", mem[0], 32'h11);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'hB0;
        acc[0] = 0; k = 1; pulses = 0; gaps = 0; gap_bad = 0; low_run = 0; started = 1'b0;
        for (int t = 1; t < 40 && pulses < 4; t++) begin
            @(negedge PCLK);
            if (rsp_valid) pulses++;
            if (!PSEL) low_run++;
            else begin
                if (started && low_run != 0) begin
                    gaps++;
                    if (low_run != 1) gap_bad++;
                end
                low_run = 0;
                started = 1'b1;
            end
            if (cmd_ready) begin
                if (k < 4) begin
                    acc[k] = t;
                    cmd_addr = k;
                    cmd_wdata = 32'hB0 + k;
                    k++;
                end else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_pulses", pulses, 4);
        chk("b2b_gaps", {gaps[7:0], gap_bad[7:0]}, {8'd3, 8'd0});
        chk("b2b_acc1", acc[1] - acc[0], 3);
        chk("b2b_acc2", acc[2] - acc[1], 3);
        chk("b2b_acc3", acc[3] - acc[2], 3);
        chk("b2b_mem", {mem[0], mem[1], mem[2], mem[3]}, {32'hB0, 32'hB1, 32'hB2, 32'hB3});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
